dipswitch_ring: RTL

- Parametrised successor of the single-switch LED rotator.
- Debounces NUM_SW DIP switch inputs and drives a one-hot (or arbitrary-pattern) LED ring of width LED_W.
- Supports manual left and right stepping on debounced rising edges, and an auto-run mode with selectable direction.
- Sits between the board DIP switches and the LED bank, all in the single clk domain.

---
 rtl/dipswitch_pkg.sv | 13 +
 rtl/ds_debounce.sv | 42 ++++
 rtl/dipswitch_ring.sv | 90 +++++++++
 3 files changed

// File: rtl/dipswitch_pkg.sv
// Shared constants for the DIP-switch LED ring: step directions and the roles
// of the first four switch channels.
package dipswitch_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned SW_STEP_L = 0;
    localparam int unsigned SW_STEP_R = 1;
    localparam int unsigned SW_AUTO   = 2;
    localparam int unsigned SW_DIR    = 3;

endpackage

// File: rtl/ds_debounce.sv
// Single switch channel: two-flop synchroniser followed by a stability counter
// that only lets the debounced level follow after DEB_CYCLES agreeing samples.
module ds_debounce #(
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // Any agreeing sample restarts the count, so short glitches never land.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dipswitch_ring.sv
// LED ring driven by debounced DIP switches: manual left/right stepping on
// rising edges plus a periodic auto-run mode with switch-selected direction.
module dipswitch_ring
    import dipswitch_pkg::*;
#(
    parameter int unsigned     NUM_SW       = 4,
    parameter int unsigned     LED_W        = 8,
    parameter int unsigned     DEB_CYCLES   = 8,
    parameter int unsigned     AUTO_PERIOD  = 50000000,
    parameter logic [LED_W-1:0] INIT_PATTERN = {{(LED_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] ds,
    output logic [LED_W-1:0]  leds,
    output logic [NUM_SW-1:0] sw_stable,
    output logic              step_pulse
);

    localparam int unsigned ACW = $clog2(AUTO_PERIOD);
    localparam logic [ACW-1:0] AUTO_MAX = ACW'(AUTO_PERIOD - 1);

    logic [NUM_SW-1:0] stable_d;
    logic [NUM_SW-1:0] rise;
    logic [ACW-1:0]    auto_cnt;
    logic [ACW-1:0]    auto_cnt_next;
    logic              man_l;
    logic              man_r;
    logic              both;
    logic              auto_en;
    logic              auto_hit;
    logic              step_go;
    logic              step_dir;
    logic [LED_W-1:0]  rot_l;
    logic [LED_W-1:0]  rot_r;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
        ds_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (ds[i]),
            .stable(sw_stable[i])
        );
    end

    assign rise  = sw_stable & ~stable_d;
    assign rot_l = {leds[LED_W-2:0], leds[LED_W-1]};
    assign rot_r = {leds[0], leds[LED_W-1:1]};

    always_comb begin
        man_l    = rise[SW_STEP_L] & ~rise[SW_STEP_R];
        man_r    = rise[SW_STEP_R] & ~rise[SW_STEP_L];
        both     = rise[SW_STEP_L] & rise[SW_STEP_R];
        auto_en  = sw_stable[SW_AUTO];
        auto_hit = auto_en && (auto_cnt == AUTO_MAX);
        // Simultaneous manual edges cancel and also swallow a coinciding auto step.
        step_go  = man_l | man_r | (auto_hit & ~both);
        if (man_r) begin
            step_dir = DIR_RIGHT;
        end else if (man_l) begin
            step_dir = DIR_LEFT;
        end else begin
            step_dir = sw_stable[SW_DIR];
        end
        if (man_l || man_r || !auto_en || auto_hit) begin
            auto_cnt_next = '0;
        end else begin
            auto_cnt_next = auto_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds       <= INIT_PATTERN;
            step_pulse <= 1'b0;
            stable_d   <= '0;
            auto_cnt   <= '0;
        end else begin
            stable_d   <= sw_stable;
            auto_cnt   <= auto_cnt_next;
            step_pulse <= step_go;
            if (step_go) begin
                leds <= (step_dir == DIR_RIGHT) ? rot_r : rot_l;
            end
        end
    end

endmodule
